sd_sector_reader: RTL

- SPI-mode SD card single-block reader (CMD17).
- Sits directly upstream of the BMP-to-SDRAM photo loader.
- Accepts a start pulse plus a sector address, then streams the 512-byte sector as 256 16-bit words with a one-cycle valid strobe.
- rd_busy falls when the sector is finished; the loader counts these falling edges as completed sectors.
- Card initialisation is done by a separate block; this block starts only after sd_init_done.

---
 rtl/sd_sector_reader.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_sector_reader.sv
// SPI-mode SD single-block reader (CMD17): streams one 512-byte sector as 256 16-bit words.
// Optional macro SD_BYTE_ADDR_EN: shift the sector address to a byte address for standard-capacity cards.
//
// state        | meaning
// -------------+------------------------------------------------------------
// S_IDLE       | sd_clk parked low, waiting for an accepted start
// S_SEND_CMD   | shifting out the 48-bit CMD17 frame
// S_WAIT_R1    | polling bytes for an R1 response (bit7 = 0)
// S_WAIT_TOKEN | polling bytes for the 0xFE start token
// S_READ_DATA  | receiving 4096 data bits, one word strobe per 16 bits
// S_READ_CRC   | clocking out and discarding the 16-bit CRC
// S_TAIL       | 8 trailing sd_clk cycles with CS asserted, then done
// S_ABORT      | 8 trailing sd_clk cycles with CS asserted, then error pulse
module sd_sector_reader #(
    parameter int          CLK_DIV       = 2,
    parameter int          R1_TIMEOUT    = 255,
    parameter logic [15:0] TOKEN_TIMEOUT = 16'd50000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        sd_init_done_i,
    input  logic        rd_start_en_i,
    input  logic [31:0] rd_sec_addr_i,
    output logic        rd_busy_o,
    output logic        rd_val_en_o,
    output logic [15:0] rd_val_data_o,
    output logic        rd_err_o,
    output logic        sd_clk_o,
    output logic        sd_cs_o,
    output logic        sd_mosi_o,
    input  logic        sd_miso_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_CMD,
        S_WAIT_R1,
        S_WAIT_TOKEN,
        S_READ_DATA,
        S_READ_CRC,
        S_TAIL,
        S_ABORT
    } state_t;

    localparam logic [7:0]  CMD17       = 8'h51;
    localparam logic [15:0] DIV_TC      = 16'(CLK_DIV - 1);
    localparam logic [15:0] R1_POLL_TC  = 16'(R1_TIMEOUT - 1);
    localparam logic [15:0] TOK_POLL_TC = TOKEN_TIMEOUT - 16'd1;
    localparam logic [12:0] CMD_BITS_TC = 13'd47;
    localparam logic [12:0] BYTE_TC     = 13'd7;
    localparam logic [12:0] DATA_TC     = 13'd4095;
    localparam logic [12:0] CRC_TC      = 13'd15;
    localparam logic [12:0] TAIL_CNT    = 13'd8;

    state_t      state_q;
    logic [15:0] div_cnt_q;
    logic        sd_clk_q;
    logic        sd_cs_q;
    logic        sd_mosi_q;
    logic        busy_q;
    logic        val_en_q;
    logic [15:0] val_data_q;
    logic        err_q;
    logic [46:0] cmd_q;
    logic [12:0] bit_cnt_q;
    logic [15:0] poll_cnt_q;
    logic [7:0]  word_cnt_q;
    logic [15:0] rx_q;

    logic [31:0] cmd_arg_d;
    logic [47:0] cmd_d;
    logic        tick_d;
    logic        rise_d;
    logic        fall_d;
    logic [15:0] rx_d;
    logic [7:0]  byte_d;
    logic        bit_tc_d;
    logic        poll_tc_d;

`ifdef SD_BYTE_ADDR_EN
    assign cmd_arg_d = {rd_sec_addr_i[22:0], 9'b0};
`else
    assign cmd_arg_d = rd_sec_addr_i;
`endif

    assign cmd_d     = {CMD17, cmd_arg_d, 8'hFF};
    assign tick_d    = (state_q != S_IDLE) && (div_cnt_q == DIV_TC);
    assign rise_d    = tick_d & ~sd_clk_q;
    assign fall_d    = tick_d & sd_clk_q;
    assign rx_d      = {rx_q[14:0], sd_miso_i};
    assign byte_d    = rx_d[7:0];
    assign bit_tc_d  = (bit_cnt_q == 13'd0);
    assign poll_tc_d = (poll_cnt_q == 16'd0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            div_cnt_q  <= '0;
            sd_clk_q   <= 1'b0;
            sd_cs_q    <= 1'b1;
            sd_mosi_q  <= 1'b1;
            busy_q     <= 1'b0;
            val_en_q   <= 1'b0;
            val_data_q <= '0;
            err_q      <= 1'b0;
            cmd_q      <= '0;
            bit_cnt_q  <= '0;
            poll_cnt_q <= '0;
            word_cnt_q <= '0;
            rx_q       <= '0;
        end else begin
            val_en_q <= 1'b0;
            err_q    <= 1'b0;

            if (state_q == S_IDLE) begin
                div_cnt_q <= '0;
            end else if (tick_d) begin
                div_cnt_q <= '0;
                sd_clk_q  <= ~sd_clk_q;
            end else begin
                div_cnt_q <= div_cnt_q + 16'd1;
            end

            if (rise_d) begin
                rx_q <= rx_d;
            end
            if (state_q != S_SEND_CMD) begin
                sd_mosi_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (rd_start_en_i && sd_init_done_i) begin
                        state_q    <= S_SEND_CMD;
                        busy_q     <= 1'b1;
                        sd_cs_q    <= 1'b0;
                        sd_mosi_q  <= cmd_d[47];
                        cmd_q      <= cmd_d[46:0];
                        bit_cnt_q  <= CMD_BITS_TC;
                        word_cnt_q <= '0;
                    end
                end

                S_SEND_CMD: begin
                    if (fall_d) begin
                        sd_mosi_q <= cmd_q[46];
                        cmd_q     <= {cmd_q[45:0], 1'b0};
                    end
                    if (rise_d) begin
                        if (bit_tc_d) begin
                            state_q    <= S_WAIT_R1;
                            bit_cnt_q  <= BYTE_TC;
                            poll_cnt_q <= R1_POLL_TC;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 13'd1;
                        end
                    end
                end

                S_WAIT_R1: begin
                    if (rise_d) begin
                        if (!bit_tc_d) begin
                            bit_cnt_q <= bit_cnt_q - 13'd1;
                        end else if (!byte_d[7]) begin
                            if (byte_d == 8'h00) begin
                                state_q    <= S_WAIT_TOKEN;
                                bit_cnt_q  <= BYTE_TC;
                                poll_cnt_q <= TOK_POLL_TC;
                            end else begin
                                state_q   <= S_ABORT;
                                bit_cnt_q <= TAIL_CNT;
                            end
                        end else if (poll_tc_d) begin
                            state_q   <= S_ABORT;
                            bit_cnt_q <= TAIL_CNT;
                        end else begin
                            bit_cnt_q  <= BYTE_TC;
                            poll_cnt_q <= poll_cnt_q - 16'd1;
                        end
                    end
                end

                S_WAIT_TOKEN: begin
                    if (rise_d) begin
                        if (!bit_tc_d) begin
                            bit_cnt_q <= bit_cnt_q - 13'd1;
                        end else if (byte_d == 8'hFE) begin
                            state_q   <= S_READ_DATA;
                            bit_cnt_q <= DATA_TC;
                        end else if (byte_d == 8'hFF && !poll_tc_d) begin
                            bit_cnt_q  <= BYTE_TC;
                            poll_cnt_q <= poll_cnt_q - 16'd1;
                        end else begin
                            state_q   <= S_ABORT;
                            bit_cnt_q <= TAIL_CNT;
                        end
                    end
                end

                S_READ_DATA: begin
                    if (rise_d) begin
                        bit_cnt_q <= bit_cnt_q - 13'd1;
                        // Bit counter runs down from 4095, so a word closes whenever the low nibble hits zero.
                        if (bit_cnt_q[3:0] == 4'd0) begin
                            val_data_q <= rx_d;
                            val_en_q   <= 1'b1;
                            word_cnt_q <= word_cnt_q + 8'd1;
                            if (word_cnt_q == 8'hFF) begin
                                state_q   <= S_READ_CRC;
                                bit_cnt_q <= CRC_TC;
                            end
                        end
                    end
                end

                S_READ_CRC: begin
                    if (rise_d) begin
                        if (bit_tc_d) begin
                            state_q   <= S_TAIL;
                            bit_cnt_q <= TAIL_CNT;
                        end else begin
                            bit_cnt_q <= bit_cnt_q - 13'd1;
                        end
                    end
                end

                S_TAIL, S_ABORT: begin
                    if (rise_d && !bit_tc_d) begin
                        bit_cnt_q <= bit_cnt_q - 13'd1;
                    end
                    // Finish on the falling edge after the 8th rise so sd_clk parks low.
                    if (fall_d && bit_tc_d) begin
                        state_q <= S_IDLE;
                        sd_cs_q <= 1'b1;
                        busy_q  <= 1'b0;
                        err_q   <= (state_q == S_ABORT);
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_busy_o     = busy_q;
    assign rd_val_en_o   = val_en_q;
    assign rd_val_data_o = val_data_q;
    assign rd_err_o      = err_q;
    assign sd_clk_o      = sd_clk_q;
    assign sd_cs_o       = sd_cs_q;
    assign sd_mosi_o     = sd_mosi_q;

endmodule
